ibex_avalon_arbiter: RTL and testbench

Shares one Avalon-MM master port between the ibex instruction-fetch and data ports, both of which use the req/gnt/rvalid protocol. It sits between ibex_core and a single Avalon interconnect port. It is used on memory systems where the instruction and data buses are merged. Each accepted request is a single-beat transfer. The arbiter tracks outstanding reads in an in-order ID FIFO so that each read response returns to its originating requester.

---
 rtl/ibex_avalon_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_ibex_avalon_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_avalon_arbiter.sv
// Merges the ibex instruction-fetch and data req/gnt/rvalid ports onto one Avalon-MM master,
// routing read responses back in order. Define ARB_ROUND_ROBIN_EN for round-robin arbitration.
module ibex_avalon_arbiter #(
    parameter int MaxOutstanding = 2,
    parameter int AddrWidth      = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 instr_req_i,
    input  logic [31:0]          instr_addr_i,
    output logic                 instr_gnt_o,
    output logic                 instr_rvalid_o,
    output logic [31:0]          instr_rdata_o,
    output logic                 instr_err_o,

    input  logic                 data_req_i,
    input  logic                 data_we_i,
    input  logic [3:0]           data_be_i,
    input  logic [31:0]          data_addr_i,
    input  logic [31:0]          data_wdata_i,
    output logic                 data_gnt_o,
    output logic                 data_rvalid_o,
    output logic [31:0]          data_rdata_o,
    output logic                 data_err_o,

    output logic [AddrWidth-1:0] avm_address,
    output logic [3:0]           avm_byteenable,
    output logic                 avm_read,
    output logic                 avm_write,
    output logic [31:0]          avm_writedata,
    input  logic [31:0]          avm_readdata,
    input  logic                 avm_waitrequest,
    input  logic                 avm_readdatavalid,
    input  logic [1:0]           avm_response,

    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WRESP = 2'd2
    } state_e;

    localparam int   PtrW        = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int   CntW        = $clog2(MaxOutstanding + 1);
    localparam logic OWNER_INSTR = 1'b0;
    localparam logic OWNER_DATA  = 1'b1;

    state_e state_q, state_d;
    logic   owner_q;

    logic [MaxOutstanding-1:0] id_mem;
    logic [PtrW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]           cnt_q;

    logic fifo_full, fifo_empty;
    logic instr_elig, data_elig, arb_valid, pick_data;
    logic issue_done, wresp, push, push_ok, pop, head_id;
    logic rsp_instr, rsp_data;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        if (p == PtrW'(MaxOutstanding - 1)) return '0;
        return p + 1'b1;
    endfunction

    assign fifo_full  = (cnt_q == CntW'(MaxOutstanding));
    assign fifo_empty = (cnt_q == '0);

    // Writes wait for an empty ID FIFO so no write can overtake an outstanding read.
    assign instr_elig = instr_req_i && !fifo_full;
    assign data_elig  = data_req_i && (data_we_i ? fifo_empty : !fifo_full);
    assign arb_valid  = instr_elig || data_elig;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_ptr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= OWNER_DATA;
        end else if (issue_done) begin
            rr_ptr_q <= ~owner_q;
        end
    end

    assign pick_data = data_elig && (!instr_elig || (rr_ptr_q == OWNER_DATA));
`else
    assign pick_data = data_elig;
`endif

    // Handshake: a requester holds req and its fields until gnt; gnt is the single cycle the
    // Avalon slave accepts the command (avm_read/avm_write high with avm_waitrequest low).
    assign issue_done = (state_q == ISSUE) && !avm_waitrequest;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_gnt_o = 1'b0;
        data_gnt_o  = 1'b0;
        wresp       = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_valid) state_d = ISSUE;
            end
            ISSUE: begin
                if (!avm_waitrequest) begin
                    instr_gnt_o = (owner_q == OWNER_INSTR);
                    data_gnt_o  = (owner_q == OWNER_DATA);
                    state_d     = avm_write ? WRESP : IDLE;
                end
            end
            WRESP: begin
                wresp   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dbg_state = state_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_q        <= OWNER_INSTR;
            avm_address    <= '0;
            avm_byteenable <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
        end else if ((state_q == IDLE) && arb_valid) begin
            owner_q <= pick_data;
            if (pick_data) begin
                avm_address    <= data_addr_i[AddrWidth-1:0];
                avm_byteenable <= data_be_i;
                avm_read       <= !data_we_i;
                avm_write      <= data_we_i;
                avm_writedata  <= data_wdata_i;
            end else begin
                avm_address    <= instr_addr_i[AddrWidth-1:0];
                avm_byteenable <= 4'hF;
                avm_read       <= 1'b1;
                avm_write      <= 1'b0;
                avm_writedata  <= '0;
            end
        end else if (issue_done) begin
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
        end
    end

    // Each accepted read records its owner; responses return in issue order.
    assign push    = issue_done && avm_read;
    assign pop     = avm_readdatavalid && !fifo_empty;
    assign push_ok = push && (!fifo_full || pop);
    assign head_id = id_mem[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_mem   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                id_mem[wr_ptr_q] <= owner_q;
                wr_ptr_q         <= next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({push_ok, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign rsp_instr = pop && (head_id == OWNER_INSTR);
    assign rsp_data  = pop && (head_id == OWNER_DATA);

    assign instr_rvalid_o = rsp_instr;
    assign instr_rdata_o  = rsp_instr ? avm_readdata : 32'h0;
    assign instr_err_o    = rsp_instr && (avm_response != 2'b00);

    assign data_rvalid_o  = rsp_data || wresp;
    assign data_rdata_o   = rsp_data ? avm_readdata : 32'h0;
    assign data_err_o     = rsp_data && (avm_response != 2'b00);

`ifndef SYNTHESIS
    // Responses to reads dropped by a reset may still arrive; only unexplained ones are flagged.
    logic [3:0] stray_budget;
    logic [3:0] strays_at_rst;

    assign strays_at_rst = 4'(cnt_q) + {3'b000, (state_q == ISSUE) && avm_read};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if (strays_at_rst > stray_budget) stray_budget <= strays_at_rst;
        end else if (avm_readdatavalid && fifo_empty) begin
            assert (stray_budget != 4'd0)
            else $error("avm_readdatavalid with no outstanding read");
            if (stray_budget != 4'd0) stray_budget <= stray_budget - 4'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ibex_avalon_arbiter.sv
// Self-checking bench for ibex_avalon_arbiter: directed scenarios followed by randomized
// requester and Avalon slave traffic checked against an in-order outstanding-read model.
module tb_ibex_avalon_arbiter;
  localparam int MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o, data_err_o;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic [31:0] avm_address, avm_writedata, avm_readdata;
  logic [3:0]  avm_byteenable;
  logic        avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
  logic [1:0]  avm_response;
  logic [1:0]  dbg_state;

  ibex_avalon_arbiter #(.MaxOutstanding(MAX_OUT), .AddrWidth(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable), .avm_read(avm_read),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
    .avm_response(avm_response), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_req_i = 1'b0; instr_addr_i = 32'h0;
    data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
    data_addr_i = 32'h0; data_wdata_i = 32'h0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
    avm_readdata = 32'h0; avm_response = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) next_cycle();
    rst = 1'b0;
  endtask

  task automatic set_data(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata);
    data_req_i = 1'b1; data_we_i = we; data_be_i = be;
    data_addr_i = addr; data_wdata_i = wdata;
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_ctl"}, {20'h0, instr_gnt_o, instr_rvalid_o, instr_err_o, data_gnt_o,
                          data_rvalid_o, data_err_o, avm_read, avm_write, avm_byteenable}, 32'h0);
    check({pfx, "_addr"}, avm_address, 32'h0);
    check({pfx, "_wdata"}, avm_writedata, 32'h0);
    check({pfx, "_rdata"}, instr_rdata_o | data_rdata_o, 32'h0);
  endtask

  // scoreboard: owners of accepted, unanswered reads (1 = data), oldest first
  logic [0:0] exp_q[$];

  initial begin
    int ngr, out;
    logic [0:0] order[4];
    logic [0:0] exp_order[4];
    bit i_pend, d_pend, wresp_due, fire, acc, exp_irv, exp_drv;
    logic [31:0] i_addr, d_addr, d_wdata, r_data;
    logic [3:0] d_be;
    logic d_we, own_c;
    logic [0:0] own;
    logic [1:0] r_resp;
    int pre;

    do_reset();
    #1;
    check_quiet("reset");

    // single fetch
    next_cycle(); instr_req_i = 1'b1; instr_addr_i = 32'h0000_0100; #1;
    check("t1_n_read", 32'(avm_read), 0);
    check("t1_n_gnt", 32'(instr_gnt_o), 0);
    next_cycle(); #1;
    check("t1_read", 32'(avm_read), 1);
    check("t1_addr", avm_address, 32'h0000_0100);
    check("t1_be", 32'(avm_byteenable), 32'hF);
    check("t1_gnt", {30'h0, instr_gnt_o, data_gnt_o}, 32'h2);
    next_cycle(); instr_req_i = 1'b0; #1;
    check("t1_deassert", 32'(avm_read), 0);
    next_cycle(); avm_readdatavalid = 1'b1; avm_readdata = 32'hDEAD_BEEF; #1;
    check("t1_rv", {30'h0, instr_rvalid_o, data_rvalid_o}, 32'h2);
    check("t1_rdata", instr_rdata_o, 32'hDEAD_BEEF);
    check("t1_err", 32'(instr_err_o), 0);
    next_cycle(); avm_readdatavalid = 1'b0; #1;
    check("t1_rv_end", 32'(instr_rvalid_o), 0);

    // simultaneous reads: data first, responses routed in order
    next_cycle(); instr_req_i = 1'b1; instr_addr_i = 32'h200;
    set_data(1'b0, 4'hF, 32'h8000_0300, 32'h0); #1;
    next_cycle(); #1;
    check("t2_d_addr", avm_address, 32'h8000_0300);
    check("t2_d_gnt", {30'h0, instr_gnt_o, data_gnt_o}, 32'h1);
    next_cycle(); data_req_i = 1'b0; #1;
    check("t2_bubble", {30'h0, avm_read, instr_gnt_o}, 32'h0);
    next_cycle(); #1;
    check("t2_i_addr", avm_address, 32'h200);
    check("t2_i_gnt", {30'h0, instr_gnt_o, data_gnt_o}, 32'h2);
    next_cycle(); instr_req_i = 1'b0; avm_readdatavalid = 1'b1; avm_readdata = 32'h11; #1;
    check("t2_rsp1_rv", {30'h0, instr_rvalid_o, data_rvalid_o}, 32'h1);
    check("t2_rsp1_data", data_rdata_o, 32'h11);
    next_cycle(); avm_readdata = 32'h22; #1;
    check("t2_rsp2_rv", {30'h0, instr_rvalid_o, data_rvalid_o}, 32'h2);
    check("t2_rsp2_data", instr_rdata_o, 32'h22);
    next_cycle(); avm_readdatavalid = 1'b0;

    // both requesters held for four grants
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    ngr = 0; out = 0;
    instr_req_i = 1'b1; instr_addr_i = 32'h300;
    set_data(1'b0, 4'hF, 32'h8000_0400, 32'h0);
    for (int c = 0; c < 40 && ngr < 4; c++) begin
      next_cycle();
      avm_readdatavalid = (out > 0); avm_readdata = 32'(c);
      #1;
      if (avm_readdatavalid) out--;
      if (data_gnt_o) begin if (ngr < 4) order[ngr] = 1'b1; ngr++; out++; end
      if (instr_gnt_o) begin if (ngr < 4) order[ngr] = 1'b0; ngr++; out++; end
    end
    instr_req_i = 1'b0; data_req_i = 1'b0;
    check("t3_grants", 32'(ngr), 4);
    for (int i = 0; i < 4; i++) check($sformatf("t3_ord%0d", i), 32'(order[i]), 32'(exp_order[i]));
    for (int c = 0; c < 10 && out > 0; c++) begin
      next_cycle(); avm_readdatavalid = 1'b1; out--;
    end
    next_cycle(); avm_readdatavalid = 1'b0;

    // write held off behind an outstanding fetch
    next_cycle(); instr_req_i = 1'b1; instr_addr_i = 32'h104; #1;
    next_cycle(); #1;
    check("t4_fetch_gnt", 32'(instr_gnt_o), 1);
    next_cycle(); instr_req_i = 1'b0; set_data(1'b1, 4'b0011, 32'h40, 32'hCAFE_F00D); #1;
    check("t4_block0", 32'(avm_write), 0);
    for (int k = 0; k < 3; k++) begin
      next_cycle(); #1;
      check("t4_block", 32'(avm_write), 0);
    end
    next_cycle(); avm_readdatavalid = 1'b1; avm_readdata = 32'h55; #1;
    check("t4_fetch_rv", 32'(instr_rvalid_o), 1);
    check("t4_block_rv", 32'(avm_write), 0);
    next_cycle(); avm_readdatavalid = 1'b0; avm_waitrequest = 1'b1; #1;
    check("t4_reg_cycle", 32'(avm_write), 0);
    for (int k = 0; k < 3; k++) begin
      next_cycle(); #1;
      check("t4_wr_held", {30'h0, avm_write, data_gnt_o}, 32'h2);
      check("t4_wdata", avm_writedata, 32'hCAFE_F00D);
      check("t4_waddr", avm_address, 32'h40);
      check("t4_wbe", 32'(avm_byteenable), 32'h3);
    end
    next_cycle(); avm_waitrequest = 1'b0; #1;
    check("t4_wgnt", {30'h0, avm_write, data_gnt_o}, 32'h3);
    next_cycle(); data_req_i = 1'b0; #1;
    check("t4_wresp", {29'h0, data_rvalid_o, data_err_o, avm_write}, 32'h4);
    next_cycle(); #1;
    check("t4_wresp_end", 32'(data_rvalid_o), 0);

    // FIFO full blocks the third fetch; error response on the first
    next_cycle(); instr_req_i = 1'b1; instr_addr_i = 32'h1000; #1;
    next_cycle(); #1;
    check("t5_g1", 32'(instr_gnt_o), 1);
    next_cycle(); instr_addr_i = 32'h1004; #1;
    next_cycle(); #1;
    check("t5_g2", 32'(instr_gnt_o), 1);
    check("t5_a2", avm_address, 32'h1004);
    next_cycle(); instr_addr_i = 32'h1008; #1;
    check("t5_full0", 32'(avm_read), 0);
    for (int k = 0; k < 3; k++) begin
      next_cycle(); #1;
      check("t5_full", 32'(avm_read), 0);
    end
    next_cycle(); avm_readdatavalid = 1'b1; avm_readdata = 32'h33; avm_response = 2'b10; #1;
    check("t5_err_beat", {29'h0, instr_rvalid_o, instr_err_o, avm_read}, 32'h6);
    check("t5_err_data", instr_rdata_o, 32'h33);
    next_cycle(); avm_readdatavalid = 1'b0; avm_response = 2'b00; #1;
    check("t5_err_clear", {29'h0, instr_rvalid_o, instr_err_o, avm_read}, 32'h0);
    next_cycle(); #1;
    check("t5_third", {31'h0, instr_gnt_o}, 32'h1);
    check("t5_a3", avm_address, 32'h1008);
    next_cycle(); instr_req_i = 1'b0; avm_readdatavalid = 1'b1; avm_readdata = 32'h44; #1;
    check("t5_rsp2", {30'h0, instr_rvalid_o, instr_err_o}, 32'h2);
    next_cycle(); avm_readdata = 32'h45; #1;
    check("t5_rsp3", {30'h0, instr_rvalid_o, instr_err_o}, 32'h2);
    next_cycle(); avm_readdatavalid = 1'b0;

    // reset while a read is stalled and another is outstanding
    next_cycle(); instr_req_i = 1'b1; instr_addr_i = 32'h2000; #1;
    next_cycle(); #1;
    check("t6_g1", 32'(instr_gnt_o), 1);
    next_cycle(); instr_req_i = 1'b0; set_data(1'b0, 4'hF, 32'h8000_2000, 32'h0);
    avm_waitrequest = 1'b1; #1;
    next_cycle(); #1;
    check("t6_stall", {30'h0, avm_read, data_gnt_o}, 32'h2);
    next_cycle(); rst = 1'b1; #1;
    next_cycle(); rst = 1'b0; data_req_i = 1'b0; avm_waitrequest = 1'b0; #1;
    check_quiet("t6_rst");
    for (int k = 0; k < 2; k++) begin
      next_cycle(); avm_readdatavalid = 1'b1; avm_readdata = 32'hBAD0 + 32'(k); #1;
      check("t6_stray_rv", {30'h0, instr_rvalid_o, data_rvalid_o}, 32'h0);
      check("t6_stray_rd", instr_rdata_o | data_rdata_o, 32'h0);
    end
    next_cycle(); avm_readdatavalid = 1'b0;

    // randomized traffic
    i_pend = 0; d_pend = 0; wresp_due = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0; d_we = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      next_cycle();
      if (cyc < 2500) begin
        if (!i_pend && $urandom_range(0, 3) == 0) begin
          i_pend = 1; i_addr = $urandom() & 32'h7FFF_FFFC;
        end
        if (!d_pend && $urandom_range(0, 2) == 0) begin
          d_pend = 1; d_we = ($urandom_range(0, 2) == 0);
          d_be = 4'($urandom_range(1, 15)); d_addr = $urandom() | 32'h8000_0000;
          d_wdata = $urandom();
        end
      end else if (!i_pend && !d_pend && !wresp_due && exp_q.size() == 0) begin
        break;
      end
      instr_req_i = i_pend; instr_addr_i = i_addr;
      data_req_i = d_pend; data_we_i = d_we; data_be_i = d_be;
      data_addr_i = d_addr; data_wdata_i = d_wdata;
      avm_waitrequest = ($urandom_range(0, 3) == 0);
      fire = (exp_q.size() > 0) && ($urandom_range(0, 1) == 0);
      r_data = $urandom();
      r_resp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      avm_readdatavalid = fire; avm_readdata = r_data; avm_response = r_resp;
      #1;
      pre = exp_q.size();
      own = 1'b0;
      if (fire) own = exp_q.pop_front();
      exp_irv = fire && (own == 1'b0);
      exp_drv = (fire && (own == 1'b1)) || wresp_due;
      check("rnd_irv", 32'(instr_rvalid_o), 32'(exp_irv));
      check("rnd_drv", 32'(data_rvalid_o), 32'(exp_drv));
      if (exp_irv) begin
        check("rnd_irdata", instr_rdata_o, r_data);
        check("rnd_ierr", 32'(instr_err_o), 32'(r_resp != 2'b00));
      end
      if (fire && own == 1'b1) begin
        check("rnd_drdata", data_rdata_o, r_data);
        check("rnd_derr", 32'(data_err_o), 32'(r_resp != 2'b00));
      end
      if (wresp_due) check("rnd_werr", 32'(data_err_o), 0);
      wresp_due = 0;
      acc = (avm_read || avm_write) && !avm_waitrequest;
      own_c = avm_address[31];
      check("rnd_igant", 32'(instr_gnt_o), 32'(acc && !own_c));
      check("rnd_dgnt", 32'(data_gnt_o), 32'(acc && own_c));
      if (acc && !own_c) begin
        check("rnd_i_pend", 32'(i_pend), 1);
        check("rnd_i_addr", avm_address, i_addr);
        check("rnd_i_cmd", {26'h0, avm_read, avm_write, avm_byteenable}, 32'h2F);
        check("rnd_i_room", 32'(pre < MAX_OUT), 1);
        exp_q.push_back(1'b0);
        i_pend = 0;
      end else if (acc) begin
        check("rnd_d_pend", 32'(d_pend), 1);
        check("rnd_d_addr", avm_address, d_addr);
        check("rnd_d_cmd", {26'h0, avm_read, avm_write, avm_byteenable}, {26'h0, !d_we, d_we, d_be});
        if (d_we) begin
          check("rnd_wdata", avm_writedata, d_wdata);
          check("rnd_w_empty", 32'(pre), 0);
          wresp_due = 1;
        end else begin
          check("rnd_d_room", 32'(pre < MAX_OUT), 1);
          exp_q.push_back(1'b1);
        end
        d_pend = 0;
      end
    end
    check("rnd_drain", 32'(exp_q.size()) + 32'(i_pend) + 32'(d_pend) + 32'(wresp_due), 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
